bp_sacc_coh_responder: RTL and testbench

- Coherence-NoC endpoint that answers accelerator-tile LCE requests; it is the responder to the tile-side initiator.
- Accepts wormhole request packets on its ready/valid-and link and services reads and writes against a local word scratchpad.
- Returns a command packet to the requester's coordinate.
- Sits behind one port of the coherence network socket, in the network clock domain.

---
 rtl/bp_sacc_coh_responder_if.sv | 11 +
 rtl/bp_sacc_coh_responder.sv | 150 +++++++++++++++
 tb/tb_bp_sacc_coh_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_sacc_coh_responder_if.sv
// Wormhole link bundle between an LCE request initiator and the coherence responder.
// Each direction carries {v, data, ready_and_rev}.
interface bp_sacc_coh_responder_if #(
  parameter int unsigned flit_width_p = 64
);
  logic [flit_width_p+1:0] link_i;
  logic [flit_width_p+1:0] link_o;

  modport slave  (input  link_i, output link_o);
  modport master (output link_i, input  link_o);
endinterface

// File: rtl/bp_sacc_coh_responder.sv
// Coherence-NoC endpoint: services single-word RD/WR requests against a local
// scratchpad and returns a response packet to the requester's coordinate.
module bp_sacc_coh_responder #(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned cord_width_p = 8,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned addr_width_p = 16,
  parameter int unsigned els_p        = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  bp_sacc_coh_responder_if.slave  link,
  output logic                    busy_o,
  output logic [7:0]              err_count_o
);

  localparam int unsigned FW       = flit_width_p;
  localparam int unsigned CW       = cord_width_p;
  localparam int unsigned LW       = len_width_p;
  localparam int unsigned AW       = addr_width_p;
  localparam int unsigned LG_ELS   = $clog2(els_p);
  localparam int unsigned LEN_LSB  = CW;
  localparam int unsigned SRC_LSB  = CW + LW;
  localparam int unsigned OP_LSB   = 2 * CW + LW;
  localparam int unsigned ADDR_LSB = 2 * CW + LW + 2;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_ACK = 2'd2;
  localparam logic [1:0] OP_ERR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_RESP_HDR, S_RESP_DATA} state_e;
  typedef enum logic [1:0] {K_RD, K_ACK, K_ERR} kind_e;

  state_e          r_state, w_state_n;
  logic [CW-1:0]   r_src;
  logic [1:0]      r_op;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_cnt;
  logic [7:0]      r_err_cnt;
  logic [FW-1:0]   r_mem [els_p];

  logic            w_in_v, w_out_ready, w_ready, w_in_fire;
  logic [FW-1:0]   w_in_data;
  logic [LW-1:0]   w_hdr_len;
  logic            w_addr_ok;
  kind_e           w_kind;
  logic [LG_ELS-1:0] w_idx;
  logic            w_out_v;
  logic [FW-1:0]   w_out_data;
  logic [FW-1:0]   w_resp_hdr;

  assign w_in_v      = link.link_i[FW+1];
  assign w_in_data   = link.link_i[FW:1];
  assign w_out_ready = link.link_i[0];
  assign w_hdr_len   = w_in_data[LEN_LSB +: LW];

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign w_ready   = reset_n_i & ((r_state == S_IDLE) | (r_state == S_RECV));
  assign w_in_fire = w_in_v & w_ready;

  assign w_idx     = r_addr[3 +: LG_ELS];
  assign w_addr_ok = (r_addr[2:0] == 3'b000) && (r_addr < AW'(els_p * 8));

  always_comb begin
    w_kind = K_ERR;
    if (w_addr_ok && r_op == OP_RD && r_len == LW'(0)) w_kind = K_RD;
    else if (w_addr_ok && r_op == OP_WR && r_len == LW'(1)) w_kind = K_ACK;
  end

  always_comb begin
    w_resp_hdr = '0;
    w_resp_hdr[0 +: CW]        = r_src;
    w_resp_hdr[LEN_LSB +: LW]  = (w_kind == K_RD) ? LW'(1) : LW'(0);
    w_resp_hdr[SRC_LSB +: CW]  = my_cord_i;
    w_resp_hdr[OP_LSB +: 2]    = (w_kind == K_RD) ? OP_RD : ((w_kind == K_ACK) ? OP_ACK : OP_ERR);
    w_resp_hdr[ADDR_LSB +: AW] = r_addr;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_out_v    = 1'b0;
    w_out_data = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_in_fire) w_state_n = (w_hdr_len != LW'(0)) ? S_RECV : S_RESP_HDR;
      end
      S_RECV: begin
        if (w_in_fire && r_cnt == LW'(1)) w_state_n = S_RESP_HDR;
      end
      S_RESP_HDR: begin
        w_out_v    = 1'b1;
        w_out_data = w_resp_hdr;
        if (w_out_ready) w_state_n = (w_kind == K_RD) ? S_RESP_DATA : S_IDLE;
      end
      S_RESP_DATA: begin
        w_out_v    = 1'b1;
        w_out_data = r_mem[w_idx];
        if (w_out_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign link.link_o = {w_out_v, w_out_data, w_ready};

  // Request capture, flit counter and error counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_src     <= '0;
      r_op      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_in_fire) begin
        r_src  <= w_in_data[SRC_LSB +: CW];
        r_op   <= w_in_data[OP_LSB +: 2];
        r_addr <= w_in_data[ADDR_LSB +: AW];
        r_len  <= w_hdr_len;
        r_cnt  <= w_hdr_len;
      end else if (r_state == S_RECV && w_in_fire) begin
        r_cnt <= r_cnt - LW'(1);
      end
      if (r_state == S_RESP_HDR && w_out_ready && w_kind == K_ERR && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // A legal WR carries exactly one data flit, so any accept in RECV is that flit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(els_p); i++) r_mem[i] <= '0;
    end else if (r_state == S_RECV && w_in_fire && w_kind == K_ACK) begin
      r_mem[w_idx] <= w_in_data;
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_bp_sacc_coh_responder.sv
// Directed bench for bp_sacc_coh_responder: RD/WR/ERR responses, hold under
// backpressure, back-to-back packets and reset mid-packet.
module tb_bp_sacc_coh_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  my_cord = 8'h05;
  logic        tb_v = 1'b0;
  logic [63:0] tb_data = '0;
  logic        tb_ready = 1'b1;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        o_v, o_ready;
  logic [63:0] o_data;

  int n_checks = 0;
  int n_errors = 0;

  bit          mon_en = 1'b0;
  logic [63:0] resp_q[$];
  bit          busy_hist[$];

  bp_sacc_coh_responder_if u_if ();

  assign u_if.link_i = {tb_v, tb_data, tb_ready};
  assign o_v     = u_if.link_o[65];
  assign o_data  = u_if.link_o[64:1];
  assign o_ready = u_if.link_o[0];

  bp_sacc_coh_responder dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .my_cord_i   (my_cord),
    .link        (u_if.slave),
    .busy_o      (busy),
    .err_count_o (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      busy_hist.push_back(busy);
      if (o_v && tb_ready) resp_q.push_back(o_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] dest, input logic [3:0] len,
                                         input logic [7:0] src, input logic [1:0] op,
                                         input logic [15:0] addr);
    return {26'b0, addr, op, src, len, dest};
  endfunction

  // Called just after a negedge; returns at the negedge following the accept.
  task automatic send_flit(input logic [63:0] d);
    int n = 0;
    tb_v = 1'b1;
    tb_data = d;
    #1;
    while (!o_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("send_rdy", {63'b0, o_ready}, 64'd1);
    @(negedge clk);
    tb_v = 1'b0;
  endtask

  task automatic recv_flit(input string tag, input logic [63:0] exp);
    int n = 0;
    tb_ready = 1'b1;
    #1;
    while (!o_v && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_v"}, {63'b0, o_v}, 64'd1);
    chk(tag, o_data, exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int gaps, max_gap, run, first, last;
    logic [63:0] exp_q[$];

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'b0, o_ready}, 64'd0);
    chk("rst_v", {63'b0, o_v}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'b0, o_ready}, 64'd1);
    chk("idle_busy", {63'b0, busy}, 64'd0);
    chk("idle_err", {56'b0, err_cnt}, 64'd0);

    // WR 0x18 -> ACK one cycle after data accept
    send_flit(mk_hdr(8'h05, 4'd1, 8'h21, 2'd1, 16'h0018));
    send_flit(64'hDEADBEEF_CAFEF00D);
    #1 chk("ack_lat", {63'b0, o_v}, 64'd1);
    recv_flit("ack_hdr", mk_hdr(8'h21, 4'd0, 8'h05, 2'd2, 16'h0018));
    chk("mem3", dut.r_mem[3], 64'hDEADBEEF_CAFEF00D);

    // RD 0x18 with 5 cycles of backpressure
    tb_ready = 1'b0;
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0018));
    #1 chk("rd_lat", {63'b0, o_v}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_v", {63'b0, o_v}, 64'd1);
      chk("hold_d", o_data, mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0018));
      @(negedge clk); #1;
    end
    @(negedge clk);
    recv_flit("rd_hdr", mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0018));
    recv_flit("rd_data", 64'hDEADBEEF_CAFEF00D);

    // Out-of-range and misaligned reads -> ERR
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0080));
    recv_flit("err_oor", mk_hdr(8'h21, 4'd0, 8'h05, 2'd3, 16'h0080));
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h001C));
    recv_flit("err_mis", mk_hdr(8'h21, 4'd0, 8'h05, 2'd3, 16'h001C));
    chk("err_cnt2", {56'b0, err_cnt}, 64'd2);
    chk("mem3_kept", dut.r_mem[3], 64'hDEADBEEF_CAFEF00D);

    // WR with len 3: drained, ERR, no write
    send_flit(mk_hdr(8'h05, 4'd3, 8'h21, 2'd1, 16'h0000));
    send_flit(64'h1111_1111_1111_1111);
    send_flit(64'h2222_2222_2222_2222);
    send_flit(64'h3333_3333_3333_3333);
    recv_flit("err_len", mk_hdr(8'h21, 4'd0, 8'h05, 2'd3, 16'h0000));
    chk("err_cnt3", {56'b0, err_cnt}, 64'd3);
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0000));
    recv_flit("rd0_hdr", mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0000));
    recv_flit("rd0_data", 64'h0);

    // Back-to-back RD, WR, RD with ready held high
    tb_ready = 1'b1;
    resp_q.delete();
    busy_hist.delete();
    mon_en = 1'b1;
    @(negedge clk);
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0018));
    send_flit(mk_hdr(8'h05, 4'd1, 8'h21, 2'd1, 16'h0008));
    send_flit(64'h01234567_89ABCDEF);
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0008));
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    exp_q = '{mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0018), 64'hDEADBEEF_CAFEF00D,
              mk_hdr(8'h21, 4'd0, 8'h05, 2'd2, 16'h0008),
              mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0008), 64'h01234567_89ABCDEF};
    chk("b2b_cnt", 64'(resp_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("b2b_resp%0d", i), (i < resp_q.size()) ? resp_q[i] : 64'hX, exp_q[i]);
    first = -1; last = -1;
    foreach (busy_hist[i]) if (busy_hist[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    gaps = 0; max_gap = 0; run = 0;
    for (int i = (first < 0) ? 0 : first; i <= last; i++) begin
      if (!busy_hist[i]) run++;
      else if (run > 0) begin
        gaps++;
        if (run > max_gap) max_gap = run;
        run = 0;
      end
    end
    chk("b2b_gaps", 64'(gaps), 64'd2);
    chk("b2b_gap_len", 64'(max_gap), 64'd1);

    // Reset asserted during RECV of a WR
    send_flit(mk_hdr(8'h05, 4'd1, 8'h21, 2'd1, 16'h0010));
    chk("recv_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {63'b0, o_ready}, 64'd0);
    chk("mrst_v", {63'b0, o_v}, 64'd0);
    chk("mrst_busy", {63'b0, busy}, 64'd0);
    chk("mrst_err", {56'b0, err_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("no_resp", {63'b0, o_v}, 64'd0);
    end
    @(negedge clk);
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0000));
    recv_flit("post_rd0_hdr", mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0000));
    recv_flit("post_rd0_data", 64'h0);
    send_flit(mk_hdr(8'h05, 4'd0, 8'h21, 2'd0, 16'h0018));
    recv_flit("post_rd18_hdr", mk_hdr(8'h21, 4'd1, 8'h05, 2'd0, 16'h0018));
    recv_flit("post_rd18_data", 64'h0);
    chk("post_err", {56'b0, err_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
